scan_chain_ctrl: RTL

- Sequencer for a serial chain of CHAIN_LEN scandtype cells.
- Chain wiring: SDI feeds cell 0; cell i Q feeds cell i+1 SDI; cell CHAIN_LEN-1 Q returns as SDO; Test is common to all cells.
- On Start the block shifts in a test pattern, optionally pulses one functional capture, shifts the chain out and compares the result against an expected word.
- Gives block-level and system-level benches one self-checking scan-test engine.

---
 rtl/scan_chain_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequencer for a serial chain of CHAIN_LEN scan cells. A run has four phases.
// It shifts a pattern into the chain MSB first, so that bit i lands in cell i.
// It can insert one functional capture cycle. It then shifts the chain back
// out and compares the unloaded word against an expected value.
//
// Ports:
//   Clock      - rising-edge clock for controller and chain
//   nReset     - synchronous active-low reset
//   Start      - request a run (sampled only in IDLE)
//   CaptureEn  - latched at Start: 1 = insert capture cycle
//   PatternIn  - word to load, bit i ends in cell i (latched at Start)
//   Expected   - compare word (latched at Start)
//   SDO        - Q of the last chain cell
//   Test       - registered scan enable to the chain
//   SDI        - registered serial data to cell 0
//   Busy       - run in progress
//   Done       - one-cycle completion pulse
//   CaptureOut - unloaded chain contents, bit i = cell i
//   Pass       - CaptureOut == Expected, valid from Done until next Done
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 6
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic                 CaptureEn,
    input  logic [CHAIN_LEN-1:0] PatternIn,
    input  logic [CHAIN_LEN-1:0] Expected,
    input  logic                 SDO,
    output logic                 Test,
    output logic                 SDI,
    output logic                 Busy,
    output logic                 Done,
    output logic [CHAIN_LEN-1:0] CaptureOut,
    output logic                 Pass
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   pat_q, pat_d;
    logic [CHAIN_LEN-1:0]   exp_q, exp_d;
    logic                   cap_en_q, cap_en_d;
    logic [CHAIN_LEN-1:0]   sr_q, sr_d;
    logic                   test_q, test_d;
    logic                   sdi_q, sdi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CHAIN_LEN-1:0]   cap_out_q, cap_out_d;
    logic                   pass_q, pass_d;
    logic [CHAIN_LEN-1:0]   sr_shift_s;

    // Unload shift register with the pre-edge SDO appended at the LSB; the
    // first bit out of the chain is cell N-1 and ends up in bit N-1.
    assign sr_shift_s = {sr_q[CHAIN_LEN-2:0], SDO};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        exp_d     = exp_q;
        cap_en_d  = cap_en_q;
        sr_d      = sr_q;
        sdi_d     = 1'b0;
        cap_out_d = cap_out_q;
        pass_d    = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_SHIFT_IN;
                    cnt_d    = '0;
                    exp_d    = Expected;
                    cap_en_d = CaptureEn;
                    // MSB goes out first; the remainder is queued left-aligned.
                    sdi_d    = PatternIn[CHAIN_LEN-1];
                    pat_d    = {PatternIn[CHAIN_LEN-2:0], 1'b0};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_IN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = cap_en_q ? ST_CAPTURE : ST_SHIFT_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    sdi_d = pat_q[CHAIN_LEN-1];
                    pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                sr_d = sr_shift_s;
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    cap_out_d = sr_shift_s;
                    pass_d    = (sr_shift_s == exp_q);
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Control outputs follow the state being entered so they are registered.
        test_d = (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
        busy_d = (state_d == ST_SHIFT_IN) || (state_d == ST_CAPTURE) ||
                 (state_d == ST_SHIFT_OUT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            exp_q     <= '0;
            cap_en_q  <= 1'b0;
            sr_q      <= '0;
            test_q    <= 1'b0;
            sdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cap_out_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            exp_q     <= exp_d;
            cap_en_q  <= cap_en_d;
            sr_q      <= sr_d;
            test_q    <= test_d;
            sdi_q     <= sdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cap_out_q <= cap_out_d;
            pass_q    <= pass_d;
        end
    end

    assign Test       = test_q;
    assign SDI        = sdi_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign CaptureOut = cap_out_q;
    assign Pass       = pass_q;

endmodule
